ddr4_cmd_issuer: RTL

- Host-side command generator that drives the DDR4 command/address pins of the emulated `dimm` directly upstream of it: `act_n`, `A`, `bg`, `ba`, `cs_n`, `cke`.
- Accepts one read/write request at a time over a valid/ready handshake.
- Tracks the open row of every bank (open-page policy) and emits the PRE/ACT/RD/WR sequence the request needs.
- Enforces tRP, tRCD, tRAS and tCCD with internal counters, so the downstream TimingFSM never sees an illegal command.

---
 rtl/ddr4_cmd_issuer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr4_cmd_issuer.sv
// ddr4_cmd_issuer: host-side DDR4 command generator with an open-page bank table.
// It takes one read/write request at a time and emits the PRE/ACT/RD/WR sequence
// that the request needs. Internal counters hold off commands until tRP, tRCD,
// tRAS and tCCD have been met.
// Command pins are registered. When the FSM sits in a command state on an edge,
// that command is driven during the cycle that follows the edge.
module ddr4_cmd_issuer #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TRAS      = 12,
  parameter int TCCD      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 cs_n,
  output logic                 cke,
  output logic                 cmd_rd,
  output logic                 cmd_wr
);

  localparam int BW    = BGWIDTH + BAWIDTH;
  localparam int NBANK = 1 << BW;
  localparam int MAXA  = (TRCD > TRP) ? TRCD : TRP;
  localparam int MAXB  = (TRAS > TCCD) ? TRAS : TCCD;
  localparam int MAXT  = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int CW    = (MAXT > 1) ? $clog2(MAXT) : 1;

  // PRE encoding: ras_n=0, cas_n=1, we_n=0, every other address bit low.
  localparam logic [ADDRWIDTH-1:0] PRE_ADDR = {{(ADDRWIDTH-16){1'b0}}, 1'b1, 15'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_WAIT_CCD
  } state_t;

  state_t               r_state;
  logic                 r_cke;
  logic                 r_csN;
  logic                 r_actN;
  logic [ADDRWIDTH-1:0] r_A;
  logic [BGWIDTH-1:0]   r_bg;
  logic [BAWIDTH-1:0]   r_ba;
  logic                 r_cmdRd;
  logic                 r_cmdWr;
  logic [CW-1:0]        r_cnt;

  logic                 r_we;
  logic [BGWIDTH-1:0]   r_reqBg;
  logic [BAWIDTH-1:0]   r_reqBa;
  logic [ADDRWIDTH-1:0] r_row;
  logic [COLWIDTH-1:0]  r_col;

  logic [NBANK-1:0]     r_openValid;
  logic [ADDRWIDTH-1:0] r_openRow [NBANK];
  logic [CW-1:0]        r_tras    [NBANK];

  logic [BW-1:0]        w_reqBank;
  logic [BW-1:0]        w_curBank;
  logic                 w_accept;
  logic                 w_hit;
  logic                 w_closed;
  logic                 w_trasZero;
  logic                 w_actIssue;
  logic [ADDRWIDTH-1:0] w_casAddr;

  assign w_reqBank  = {req_bg, req_ba};
  assign w_curBank  = {r_reqBg, r_reqBa};
  assign req_ready  = (r_state == S_IDLE) && r_cke;
  assign w_accept   = req_valid && req_ready;
  assign w_closed   = !r_openValid[w_reqBank];
  assign w_hit      = r_openValid[w_reqBank] && (r_openRow[w_reqBank] == req_row);
  assign w_trasZero = (r_tras[w_curBank] == '0);
  assign w_actIssue = (r_state == S_ACT);

  assign act_n  = r_actN;
  assign A      = r_A;
  assign bg     = r_bg;
  assign ba     = r_ba;
  assign cs_n   = r_csN;
  assign cke    = r_cke;
  assign cmd_rd = r_cmdRd;
  assign cmd_wr = r_cmdWr;

  // CAS address word: ras_n=1, cas_n=0, we_n=~we, A10 (auto-precharge) kept low, column in the low bits.
  always_comb begin
    w_casAddr                 = '0;
    w_casAddr[COLWIDTH-1:0]   = r_col;
    w_casAddr[16]             = 1'b1;
    w_casAddr[14]             = ~r_we;
  end

  // Per-bank tRAS guards: loaded when the bank is activated, then count down to zero and stay there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBANK; i++) begin
        r_tras[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (w_actIssue && (w_curBank == BW'(i))) begin
          r_tras[i] <= CW'(TRAS - 1);
        end else if (r_tras[i] != '0) begin
          r_tras[i] <= r_tras[i] - CW'(1);
        end
      end
    end
  end

  // Command sequencer: accepts requests, tracks open rows, paces commands and drives the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cke       <= 1'b0;
      r_csN       <= 1'b1;
      r_actN      <= 1'b1;
      r_A         <= '0;
      r_bg        <= '0;
      r_ba        <= '0;
      r_cmdRd     <= 1'b0;
      r_cmdWr     <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_reqBg     <= '0;
      r_reqBa     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_openValid <= '0;
      for (int i = 0; i < NBANK; i++) begin
        r_openRow[i] <= '0;
      end
    end else begin
      r_cke   <= 1'b1;
      r_csN   <= 1'b1;
      r_actN  <= 1'b1;
      r_A     <= '0;
      r_cmdRd <= 1'b0;
      r_cmdWr <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_reqBg <= req_bg;
            r_reqBa <= req_ba;
            r_row   <= req_row;
            r_col   <= req_col;
            if (w_hit) begin
              r_state <= S_CAS;
            end else if (w_closed) begin
              r_state <= S_ACT;
            end else begin
              r_state <= S_PRE;
            end
          end
        end

        S_PRE: begin
          if (w_trasZero) begin
            r_csN                  <= 1'b0;
            r_A                    <= PRE_ADDR;
            r_bg                   <= r_reqBg;
            r_ba                   <= r_reqBa;
            r_openValid[w_curBank] <= 1'b0;
            r_cnt                  <= CW'(TRP - 1);
            r_state                <= (TRP > 1) ? S_WAIT_RP : S_ACT;
          end
        end

        S_WAIT_RP: begin
          if (r_cnt <= CW'(1)) begin
            r_state <= S_ACT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_ACT: begin
          r_csN                  <= 1'b0;
          r_actN                 <= 1'b0;
          r_A                    <= r_row;
          r_bg                   <= r_reqBg;
          r_ba                   <= r_reqBa;
          r_openValid[w_curBank] <= 1'b1;
          r_openRow[w_curBank]   <= r_row;
          r_cnt                  <= CW'(TRCD - 1);
          r_state                <= (TRCD > 1) ? S_WAIT_RCD : S_CAS;
        end

        S_WAIT_RCD: begin
          if (r_cnt <= CW'(1)) begin
            r_state <= S_CAS;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_CAS: begin
          r_csN   <= 1'b0;
          r_A     <= w_casAddr;
          r_bg    <= r_reqBg;
          r_ba    <= r_reqBa;
          r_cmdRd <= ~r_we;
          r_cmdWr <= r_we;
          r_cnt   <= CW'(TCCD - 1);
          r_state <= S_WAIT_CCD;
        end

        S_WAIT_CCD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
